// File: rtl/biriscv_csr_writeback.sv
// CSR writeback pipeline: carries CSR results from E1 through E2 to WB, merges
// late LSU/interrupt exceptions in E2 and drives the CSR file, rd write and flush.
module biriscv_csr_writeback (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        e1_valid_i,
    input  logic [31:0] e1_pc_i,
    input  logic [31:0] e1_opcode_i,
    input  logic [31:0] csr_result_e1_value_i,
    input  logic        csr_result_e1_write_i,
    input  logic [31:0] csr_result_e1_wdata_i,
    input  logic [5:0]  csr_result_e1_exception_i,

    input  logic        stall_i,
    input  logic        squash_e1_i,
    input  logic [5:0]  mem_exception_e2_i,
    input  logic [31:0] mem_badaddr_e2_i,
    input  logic        take_interrupt_i,

    output logic        csr_writeback_write_o,
    output logic [11:0] csr_writeback_waddr_o,
    output logic [31:0] csr_writeback_wdata_o,
    output logic [5:0]  csr_writeback_exception_o,
    output logic [31:0] csr_writeback_exception_pc_o,
    output logic [31:0] csr_writeback_exception_addr_o,

    output logic        wb_rd_valid_o,
    output logic [31:0] wb_rd_value_o,
    output logic        flush_o
);

    localparam logic [5:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [5:0] EXCEPTION_INTERRUPT           = 6'h20;
    localparam logic [5:0] EXCEPTION_FENCE               = 6'h34;

    // E1 handshake: an instruction is accepted when e1_valid_i=1 and none of
    // stall_i, squash_e1_i or flush_o is high; there is no ready back to E1,
    // the upstream stage holds its instruction itself while stall_i is high.
    logic        e2_valid_q, e2_valid_d;
    logic [31:0] e2_pc_q, e2_pc_d;
    logic [11:0] e2_csr_addr_q, e2_csr_addr_d;
    logic [4:0]  e2_rd_q, e2_rd_d;
    logic [31:0] e2_value_q, e2_value_d;
    logic        e2_write_q, e2_write_d;
    logic [31:0] e2_wdata_q, e2_wdata_d;
    logic [5:0]  e2_exc_q, e2_exc_d;

    logic        wb_write_q, wb_write_d;
    logic [11:0] wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [5:0]  wb_exc_q, wb_exc_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic        wb_rd_valid_q, wb_rd_valid_d;
    logic [31:0] wb_rd_value_q, wb_rd_value_d;
    logic        flush_q, flush_d;

    logic [5:0]  exc_merged;
    logic        mem_sel;
    logic        commit_ok;

    always_comb begin
        e2_valid_d    = e2_valid_q;
        e2_pc_d       = e2_pc_q;
        e2_csr_addr_d = e2_csr_addr_q;
        e2_rd_d       = e2_rd_q;
        e2_value_d    = e2_value_q;
        e2_write_d    = e2_write_q;
        e2_wdata_d    = e2_wdata_q;
        e2_exc_d      = e2_exc_q;
        if (flush_q || !stall_i) begin
            e2_valid_d    = 1'b0;
            e2_pc_d       = '0;
            e2_csr_addr_d = '0;
            e2_rd_d       = '0;
            e2_value_d    = '0;
            e2_write_d    = 1'b0;
            e2_wdata_d    = '0;
            e2_exc_d      = '0;
            if (!flush_q && e1_valid_i && !squash_e1_i) begin
                e2_valid_d    = 1'b1;
                e2_pc_d       = e1_pc_i;
                e2_csr_addr_d = e1_opcode_i[31:20];
                e2_rd_d       = e1_opcode_i[11:7];
                e2_value_d    = csr_result_e1_value_i;
                e2_write_d    = csr_result_e1_write_i;
                e2_wdata_d    = csr_result_e1_wdata_i;
                e2_exc_d      = csr_result_e1_exception_i;
            end
        end
    end

    // Exception priority: instruction's own CSR fault, then LSU, then interrupt.
    always_comb begin
        mem_sel    = 1'b0;
        exc_merged = '0;
        if (e2_exc_q != '0) begin
            exc_merged = e2_exc_q;
        end else if (mem_exception_e2_i != '0) begin
            exc_merged = mem_exception_e2_i;
            mem_sel    = 1'b1;
        end else if (take_interrupt_i) begin
            exc_merged = EXCEPTION_INTERRUPT;
        end
        commit_ok = (exc_merged == '0) || (exc_merged == EXCEPTION_FENCE);
    end

    always_comb begin
        wb_write_d     = 1'b0;
        wb_waddr_d     = '0;
        wb_wdata_d     = '0;
        wb_exc_d       = '0;
        wb_pc_d        = '0;
        wb_addr_d      = '0;
        wb_rd_valid_d  = 1'b0;
        wb_rd_value_d  = '0;
        flush_d        = 1'b0;
        // Stall and flush both push a bubble into WB; E2 is promoted only when free to move.
        if (e2_valid_q && !stall_i && !flush_q) begin
            wb_write_d    = e2_write_q && commit_ok;
            wb_waddr_d    = (e2_write_q && commit_ok) ? e2_csr_addr_q : 12'h000;
            wb_wdata_d    = e2_wdata_q;
            wb_exc_d      = exc_merged;
            wb_pc_d       = e2_pc_q;
            if (exc_merged == EXCEPTION_ILLEGAL_INSTRUCTION)
                wb_addr_d = e2_value_q;
            else if (mem_sel)
                wb_addr_d = mem_badaddr_e2_i;
            wb_rd_valid_d = e2_write_q && commit_ok && (e2_rd_q != 5'd0);
            wb_rd_value_d = (e2_write_q && commit_ok && (e2_rd_q != 5'd0)) ? e2_value_q : 32'h0;
            flush_d       = (exc_merged != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e2_valid_q    <= 1'b0;
            e2_pc_q       <= '0;
            e2_csr_addr_q <= '0;
            e2_rd_q       <= '0;
            e2_value_q    <= '0;
            e2_write_q    <= 1'b0;
            e2_wdata_q    <= '0;
            e2_exc_q      <= '0;
            wb_write_q    <= 1'b0;
            wb_waddr_q    <= '0;
            wb_wdata_q    <= '0;
            wb_exc_q      <= '0;
            wb_pc_q       <= '0;
            wb_addr_q     <= '0;
            wb_rd_valid_q <= 1'b0;
            wb_rd_value_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            e2_valid_q    <= e2_valid_d;
            e2_pc_q       <= e2_pc_d;
            e2_csr_addr_q <= e2_csr_addr_d;
            e2_rd_q       <= e2_rd_d;
            e2_value_q    <= e2_value_d;
            e2_write_q    <= e2_write_d;
            e2_wdata_q    <= e2_wdata_d;
            e2_exc_q      <= e2_exc_d;
            wb_write_q    <= wb_write_d;
            wb_waddr_q    <= wb_waddr_d;
            wb_wdata_q    <= wb_wdata_d;
            wb_exc_q      <= wb_exc_d;
            wb_pc_q       <= wb_pc_d;
            wb_addr_q     <= wb_addr_d;
            wb_rd_valid_q <= wb_rd_valid_d;
            wb_rd_value_q <= wb_rd_value_d;
            flush_q       <= flush_d;
        end
    end

    assign csr_writeback_write_o          = wb_write_q;
    assign csr_writeback_waddr_o          = wb_waddr_q;
    assign csr_writeback_wdata_o          = wb_wdata_q;
    assign csr_writeback_exception_o      = wb_exc_q;
    assign csr_writeback_exception_pc_o   = wb_pc_q;
    assign csr_writeback_exception_addr_o = wb_addr_q;
    assign wb_rd_valid_o                  = wb_rd_valid_q;
    assign wb_rd_value_o                  = wb_rd_value_q;
    assign flush_o                        = flush_q;

endmodule

// File: tb/tb_biriscv_csr_writeback.sv
// Scoreboard bench for biriscv_csr_writeback: directed instructions push their
// expected WB image and arrival cycle; a monitor compares whatever WB shows.
module tb_biriscv_csr_writeback;

    localparam int OW = 149;
    localparam int EW = OW + 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        e1_valid;
    logic [31:0] e1_pc, e1_opcode, e1_value, e1_wdata;
    logic        e1_write;
    logic [5:0]  e1_exc;
    logic        stall, squash;
    logic [5:0]  mem_exc;
    logic [31:0] mem_badaddr;
    logic        take_int;

    logic        wr_o;
    logic [11:0] waddr_o;
    logic [31:0] wdata_o;
    logic [5:0]  exc_o;
    logic [31:0] epc_o, eaddr_o;
    logic        rd_valid_o;
    logic [31:0] rd_value_o;
    logic        flush_o;

    logic [OW-1:0] out_vec;
    logic [EW-1:0] exp_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    biriscv_csr_writeback dut (
        .clk_i                          (clk),
        .rst_i                          (rst),
        .e1_valid_i                     (e1_valid),
        .e1_pc_i                        (e1_pc),
        .e1_opcode_i                    (e1_opcode),
        .csr_result_e1_value_i          (e1_value),
        .csr_result_e1_write_i          (e1_write),
        .csr_result_e1_wdata_i          (e1_wdata),
        .csr_result_e1_exception_i      (e1_exc),
        .stall_i                        (stall),
        .squash_e1_i                    (squash),
        .mem_exception_e2_i             (mem_exc),
        .mem_badaddr_e2_i               (mem_badaddr),
        .take_interrupt_i               (take_int),
        .csr_writeback_write_o          (wr_o),
        .csr_writeback_waddr_o          (waddr_o),
        .csr_writeback_wdata_o          (wdata_o),
        .csr_writeback_exception_o      (exc_o),
        .csr_writeback_exception_pc_o   (epc_o),
        .csr_writeback_exception_addr_o (eaddr_o),
        .wb_rd_valid_o                  (rd_valid_o),
        .wb_rd_value_o                  (rd_value_o),
        .flush_o                        (flush_o)
    );

    assign out_vec = {wr_o, waddr_o, wdata_o, exc_o, epc_o, eaddr_o, rd_valid_o, rd_value_o, flush_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        e1_valid = 1'b0; e1_pc = '0; e1_opcode = '0; e1_value = '0;
        e1_write = 1'b0; e1_wdata = '0; e1_exc = '0;
        stall = 1'b0; squash = 1'b0; mem_exc = '0; mem_badaddr = '0; take_int = 1'b0;
    endtask

    task automatic drive_e1(input logic [31:0] pc, input logic [31:0] op, input logic [31:0] val,
                            input logic wr, input logic [31:0] wd, input logic [5:0] ex);
        e1_valid = 1'b1; e1_pc = pc; e1_opcode = op; e1_value = val;
        e1_write = wr; e1_wdata = wd; e1_exc = ex;
    endtask

    task automatic push_exp(input int at, input logic wr, input logic [11:0] wa, input logic [31:0] wd,
                            input logic [5:0] ex, input logic [31:0] epc, input logic [31:0] ea,
                            input logic rdv, input logic [31:0] rdval, input logic fl);
        logic [15:0] at16;
        at16 = at[15:0];
        exp_q.push_back({at16, wr, wa, wd, ex, epc, ea, rdv, rdval, fl});
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (out_vec !== '0) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h required all zero", name, cyc, out_vec);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [15:0] c16;
        if (mon_en) begin
            c16 = cyc[15:0];
            if (out_vec !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got=%h required nothing", cyc, out_vec);
                end else begin
                    e = exp_q.pop_front();
                    if ({c16, out_vec} !== e) begin
                        errors++;
                        $display("FAIL wb_output cyc=%0d got=%h required cyc=%0d %h",
                                 cyc, out_vec, e[EW-1:OW], e[OW-1:0]);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0][EW-1:OW] <= c16) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_output cyc=%0d got=0 required cyc=%0d %h",
                         cyc, e[EW-1:OW], e[OW-1:0]);
            end
        end
    end

    initial begin
        clear_in();
        rst = 1'b1;
        tick(); tick(); tick();
        check_zero("reset_state");
        rst = 1'b0;
        tick();
        check_zero("after_reset");
        mon_en = 1'b1;

        // Plain csrrw to mscratch, rd=x0
        drive_e1(32'h8000_0000, 32'h3402_9073, 32'h0000_0055, 1'b1, 32'h0000_1234, 6'h00);
        push_exp(cyc + 2, 1'b1, 12'h340, 32'h1234, 6'h00, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        // Back-to-back csrrs with rd=x11
        drive_e1(32'h8000_0004, 32'h3000_25F3, 32'hCAFE_0001, 1'b1, 32'h0000_A5A5, 6'h00);
        push_exp(cyc + 2, 1'b1, 12'h300, 32'hA5A5, 6'h00, 32'h8000_0004, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0);
        tick();
        clear_in();
        tick(); tick(); tick();

        // Illegal instruction followed by two younger csrrw that must be killed
        drive_e1(32'h8000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0077, 6'h12);
        push_exp(cyc + 2, 1'b0, 12'h000, 32'h77, 6'h12, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        tick();
        drive_e1(32'h8000_0014, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0BAD, 6'h00);
        tick();
        drive_e1(32'h8000_0018, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0BAE, 6'h00);
        tick();
        clear_in();
        tick(); tick(); tick();

        // ECALL beats a simultaneous load fault
        drive_e1(32'h8000_0020, 32'h0000_0073, 32'h0, 1'b1, 32'h0, 6'h18);
        push_exp(cyc + 2, 1'b0, 12'h000, 32'h0, 6'h18, 32'h8000_0020, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        clear_in();
        mem_exc = 6'h15; mem_badaddr = 32'hDEAD_0000;
        tick();
        clear_in();
        tick(); tick();

        // Load fault alone reports the bad address
        drive_e1(32'h8000_0030, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0005, 6'h00);
        push_exp(cyc + 2, 1'b0, 12'h000, 32'h5, 6'h15, 32'h8000_0030, 32'h1000_0004, 1'b0, 32'h0, 1'b1);
        tick();
        clear_in();
        mem_exc = 6'h15; mem_badaddr = 32'h1000_0004;
        tick();
        clear_in();
        tick(); tick();

        // Interrupt attaches to the E2 instruction
        drive_e1(32'h8000_0040, 32'h3000_25F3, 32'h0000_0011, 1'b1, 32'h0000_0009, 6'h00);
        push_exp(cyc + 2, 1'b0, 12'h000, 32'h9, 6'h20, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        clear_in();
        take_int = 1'b1;
        tick();
        clear_in();
        tick(); tick();

        // Interrupt with an empty pipeline is ignored
        take_int = 1'b1;
        tick(); tick(); tick();
        clear_in();
        tick();

        // FENCE still commits the CSR and rd writes but flushes
        drive_e1(32'h8000_0050, 32'h3000_25F3, 32'h0000_BEEF, 1'b1, 32'h0000_0042, 6'h34);
        push_exp(cyc + 2, 1'b1, 12'h300, 32'h42, 6'h34, 32'h8000_0050, 32'h0, 1'b1, 32'hBEEF, 1'b1);
        tick();
        clear_in();
        tick(); tick(); tick();

        // Squashed E1 never enters the pipe
        drive_e1(32'h8000_0058, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0111, 6'h00);
        squash = 1'b1;
        tick();
        clear_in();
        tick(); tick();

        // Three stall cycles delay the write by three cycles, one pulse only
        drive_e1(32'h8000_005C, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_5A5A, 6'h00);
        push_exp(cyc + 5, 1'b1, 12'h340, 32'h5A5A, 6'h00, 32'h8000_005C, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_in();
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0;
        tick(); tick(); tick();

        // Flush beats stall: the younger csrrw is discarded
        drive_e1(32'h8000_0060, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 6'h12);
        push_exp(cyc + 2, 1'b0, 12'h000, 32'h0, 6'h12, 32'h8000_0060, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        tick();
        drive_e1(32'h8000_0064, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0C0C, 6'h00);
        tick();
        clear_in();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick(); tick(); tick();

        // Reset with both stages occupied
        drive_e1(32'h8000_0070, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0070, 6'h00);
        push_exp(cyc + 2, 1'b1, 12'h340, 32'h70, 6'h00, 32'h8000_0070, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_e1(32'h8000_0074, 32'h3402_9073, 32'h0, 1'b1, 32'h0000_0074, 6'h00);
        tick();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("reset_midflight");
        tick(); tick(); tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
